// File: rtl/icache_pkg.sv
// icache_pkg: shared widths, FSM state encoding and address-split helpers
// for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIT_ACK = 2'd1,
    REFILL  = 2'd2
  } state_e;

  // Number of word-offset bits inside a line.
  function automatic int off_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Number of line-index bits.
  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  // Tag bits: everything above byte, offset and index fields.
  function automatic int tag_bits(input int lines, input int words_per_line);
    return ADDR_W - 2 - off_bits(words_per_line) - idx_bits(lines);
  endfunction

endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-side and memory-side req/ack bundles used by the cache.
// The cache is the slave of icache_fe_if and the master of icache_mem_if.
interface icache_fe_if;
  import icache_pkg::*;

  logic              fe_req;
  logic [ADDR_W-1:0] fe_addr;
  logic              fe_ack;
  logic [WORD_W-1:0] fe_data;

  modport master (output fe_req, output fe_addr, input  fe_ack, input  fe_data);
  modport slave  (input  fe_req, input  fe_addr, output fe_ack, output fe_data);
endinterface

interface icache_mem_if;
  import icache_pkg::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_data;

  modport master (output mem_req, output mem_addr, input  mem_ack, input  mem_data);
  modport slave  (input  mem_req, input  mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/icache_array.sv
// icache_array: tag, valid and data storage for the direct-mapped cache.
// Lookup is purely combinational; one data word can be written per cycle,
// and a tag install optionally marks the line valid. Only valid bits reset.
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  // lookup
  input  logic [idx_bits(LINES)-1:0]                  lk_idx_i,
  input  logic [off_bits(WORDS_PER_LINE)-1:0]         lk_off_i,
  input  logic [tag_bits(LINES, WORDS_PER_LINE)-1:0]  lk_tag_i,
  output logic                                        lk_hit_o,
  output logic [WORD_W-1:0]                           lk_data_o,
  // refill word write
  input  logic                                        wr_en_i,
  input  logic [idx_bits(LINES)-1:0]                  wr_idx_i,
  input  logic [off_bits(WORDS_PER_LINE)-1:0]         wr_off_i,
  input  logic [WORD_W-1:0]                           wr_data_i,
  // tag install at end of refill
  input  logic                                        inst_en_i,
  input  logic [tag_bits(LINES, WORDS_PER_LINE)-1:0]  inst_tag_i,
  input  logic                                        inst_valid_i,
  // invalidate every line
  input  logic                                        clr_i
);

  localparam int IB = idx_bits(LINES);
  localparam int OB = off_bits(WORDS_PER_LINE);
  localparam int TB = tag_bits(LINES, WORDS_PER_LINE);

  logic [LINES-1:0] valid_q;
  logic [TB-1:0]    tag_q  [LINES];
  logic [WORD_W-1:0] data_q [LINES][WORDS_PER_LINE];

  assign lk_hit_o  = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
  assign lk_data_o = data_q[lk_idx_i][lk_off_i];

  // Valid bits: invalidate-all wins over a same-cycle install.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
    end else if (inst_en_i) begin
      valid_q[wr_idx_i] <= inst_valid_i;
    end
  end

  // Tag storage, written once per completed refill.
  always_ff @(posedge clk) begin
    if (inst_en_i) begin
      tag_q[wr_idx_i] <= inst_tag_i;
    end
  end

  // Data storage, one refill word per memory ack.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache. Responds to the fetch
// stage on fe (req/ack) and refills whole lines word by word over mem.
// Optional macro ICACHE_FENCEI_EN adds a flush input (fence.i) that
// invalidates every line.
module icache
  import icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic         clk,
  input  logic         reset_n,
`ifdef ICACHE_FENCEI_EN
  input  logic         flush,
`endif
  icache_fe_if.slave   fe,
  icache_mem_if.master mem
);

  localparam int OB = off_bits(WORDS_PER_LINE);
  localparam int IB = idx_bits(LINES);
  localparam int TB = tag_bits(LINES, WORDS_PER_LINE);
  localparam logic [OB-1:0] LAST_WORD = OB'(WORDS_PER_LINE - 1);

  state_e            state_q, state_d;
  logic              fe_ack_q, fe_ack_d;
  logic [WORD_W-1:0] fe_data_q, fe_data_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [OB-1:0]     cnt_q, cnt_d;

  logic [OB-1:0]     lk_off;
  logic [IB-1:0]     lk_idx;
  logic [TB-1:0]     lk_tag;
  logic              lk_hit;
  logic [WORD_W-1:0] lk_data;

  logic [IB-1:0]     rf_idx;
  logic [TB-1:0]     rf_tag;
  logic              wr_en;
  logic              inst_en;
  logic              inst_valid;

  logic              flush_now;
  logic              block_valid;
  logic              unused_addr_bits;

  // Fetch address split; byte bits are ignored.
  assign lk_off = fe.fe_addr[OB+1:2];
  assign lk_idx = fe.fe_addr[OB+IB+1:OB+2];
  assign lk_tag = fe.fe_addr[ADDR_W-1:OB+IB+2];
  assign unused_addr_bits = ^fe.fe_addr[1:0];

  // mem_addr_q only walks the offset field during a refill, so its upper
  // bits name the line being filled.
  assign rf_idx = mem_addr_q[OB+IB+1:OB+2];
  assign rf_tag = mem_addr_q[ADDR_W-1:OB+IB+2];

`ifdef ICACHE_FENCEI_EN
  logic fpend_q, fpend_d;

  assign flush_now   = flush;
  assign block_valid = fpend_q | flush;

  // A flush seen while refilling keeps that line from being marked valid.
  always_comb begin
    fpend_d = (state_q == REFILL) && (fpend_q || flush);
  end

  // Flush-pending flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fpend_q <= 1'b0;
    else          fpend_q <= fpend_d;
  end
`else
  assign flush_now   = 1'b0;
  assign block_valid = 1'b0;
`endif

  icache_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_array (
    .clk          (clk),
    .reset_n      (reset_n),
    .lk_idx_i     (lk_idx),
    .lk_off_i     (lk_off),
    .lk_tag_i     (lk_tag),
    .lk_hit_o     (lk_hit),
    .lk_data_o    (lk_data),
    .wr_en_i      (wr_en),
    .wr_idx_i     (rf_idx),
    .wr_off_i     (cnt_q),
    .wr_data_i    (mem.mem_data),
    .inst_en_i    (inst_en),
    .inst_tag_i   (rf_tag),
    .inst_valid_i (inst_valid),
    .clr_i        (flush_now)
  );

  // Next-state and output logic: lookup in IDLE, one-cycle ack, line refill.
  always_comb begin
    state_d    = state_q;
    fe_ack_d   = 1'b0;
    fe_data_d  = fe_data_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    cnt_d      = cnt_q;
    wr_en      = 1'b0;
    inst_en    = 1'b0;
    inst_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (fe.fe_req) begin
          if (lk_hit && !flush_now) begin
            state_d   = HIT_ACK;
            fe_ack_d  = 1'b1;
            fe_data_d = lk_data;
          end else begin
            state_d    = REFILL;
            mem_req_d  = 1'b1;
            mem_addr_d = {fe.fe_addr[ADDR_W-1:OB+2], {(OB+2){1'b0}}};
            cnt_d      = '0;
          end
        end
      end
      HIT_ACK: begin
        state_d = IDLE;
      end
      REFILL: begin
        if (mem.mem_ack) begin
          wr_en = 1'b1;
          if (cnt_q == LAST_WORD) begin
            inst_en    = 1'b1;
            inst_valid = !block_valid;
            mem_req_d  = 1'b0;
            state_d    = IDLE;
          end else begin
            cnt_d      = cnt_q + OB'(1);
            mem_addr_d = mem_addr_q + 32'd4;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fe_ack_q   <= 1'b0;
      fe_data_q  <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fe_ack_q   <= fe_ack_d;
      fe_data_q  <= fe_data_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign fe.fe_ack    = fe_ack_q;
  assign fe.fe_data   = fe_data_q;
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache (LINES=16, WORDS_PER_LINE=4).
// Stimulus pushes expected fetch data and expected refill addresses into
// queues; a fetch monitor and a memory responder pop and compare them.
module tb_icache;

  localparam int WPL     = 4;
  localparam int MEM_LAT = 1;

  logic clk;
  logic reset_n;
`ifdef ICACHE_FENCEI_EN
  logic flush;
`endif

  icache_fe_if  fe_bus ();
  icache_mem_if mem_bus ();

  icache #(
    .LINES          (16),
    .WORDS_PER_LINE (WPL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef ICACHE_FENCEI_EN
    .flush   (flush),
`endif
    .fe      (fe_bus),
    .mem     (mem_bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_acks = 0;
  int last_ack_cyc = 0;

  logic [31:0] fe_q  [$];
  logic [31:0] mem_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory image: word at a is {~a[15:0], a[15:0]}, e.g. 0x100 -> 0xFEFF0100.
  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return {~w[15:0], w[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_line(input logic [31:0] a);
    logic [31:0] base;
    base = a & 32'hFFFF_FFF0;
    for (int i = 0; i < WPL; i++) mem_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_ack(output int c);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (fe_bus.fe_ack !== 1'b1 && n < 400);
    if (fe_bus.fe_ack !== 1'b1) chk("ack_timeout", 32'(fe_bus.fe_ack), 32'd1);
    c = cyc;
  endtask

  task automatic wait_mem(input int target);
    int n;
    n = 0;
    while (mem_acks < target && n < 400) begin
      step();
      n++;
    end
    chk("mem_wait", 32'(mem_acks >= target), 32'd1);
  endtask

  task automatic fetch_hit(input logic [31:0] a, input int lat);
    int c0, c1, m0;
    fe_q.push_back(memword(a));
    m0 = mem_acks;
    c0 = cyc;
    fe_bus.fe_addr = a;
    fe_bus.fe_req  = 1'b1;
    wait_ack(c1);
    chk("hit_latency", 32'(c1 - c0), 32'(lat));
    chk("hit_mem_req", 32'(mem_bus.mem_req), 32'd0);
    chk("hit_mem_acks", 32'(mem_acks - m0), 32'd0);
    fe_bus.fe_req = 1'b0;
  endtask

  task automatic fetch_miss(input logic [31:0] a);
    int c1, m0;
    fe_q.push_back(memword(a));
    push_line(a);
    m0 = mem_acks;
    fe_bus.fe_addr = a;
    fe_bus.fe_req  = 1'b1;
    wait_ack(c1);
    chk("miss_words", 32'(mem_acks - m0), 32'(WPL));
    chk("miss_ack_delay", 32'(c1 - last_ack_cyc), 32'd2);
    fe_bus.fe_req = 1'b0;
  endtask

  // Fetch monitor: every ack must match the oldest expected word.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (fe_bus.fe_ack === 1'b1) begin
        if (fe_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: data %h with nothing expected", fe_bus.fe_data);
        end else begin
          chk("fe_data", fe_bus.fe_data, fe_q.pop_front());
        end
      end
    end
  end

  // Memory responder: acks each held request after MEM_LAT idle cycles
  // and checks the refill address order.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_bus.mem_ack  = 1'b0;
    mem_bus.mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        mem_bus.mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_bus.mem_ack) begin
        mem_bus.mem_ack = 1'b0;
      end else if (mem_bus.mem_req) begin
        if (wcnt == MEM_LAT) begin
          wcnt = 0;
          if (mem_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem_req: addr %h with nothing expected", mem_bus.mem_addr);
          end else begin
            chk("mem_addr", mem_bus.mem_addr, mem_q.pop_front());
          end
          mem_bus.mem_data = memword(mem_bus.mem_addr);
          mem_bus.mem_ack  = 1'b1;
          mem_acks++;
          last_ack_cyc = cyc;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Watchdog.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, m0;
    reset_n        = 1'b0;
    fe_bus.fe_req  = 1'b0;
    fe_bus.fe_addr = '0;
`ifdef ICACHE_FENCEI_EN
    flush = 1'b0;
`endif
    idle(2);
    chk("rst_fe_ack", 32'(fe_bus.fe_ack), 32'd0);
    chk("rst_fe_data", fe_bus.fe_data, 32'd0);
    chk("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_mem_addr", mem_bus.mem_addr, 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Cold miss, then hits in the same line (first from idle, rest back-to-back).
    fetch_miss(32'h0000_0100);
    idle(2);
    fetch_hit(32'h0000_0108, 1);
    fetch_hit(32'h0000_0104, 2);
    fetch_hit(32'h0000_010C, 2);
    fetch_hit(32'h0000_0101, 2);
    idle(2);

    // Conflict eviction on index 0.
    fetch_miss(32'h0000_0200);
    idle(2);
    fetch_miss(32'h0000_0100);
    idle(2);
    fetch_hit(32'h0000_0104, 1);
    idle(2);

    // Redirect mid-refill: evict 0x100 first, then move from 0x100 to 0x340.
    fetch_miss(32'h0000_0200);
    idle(2);
    push_line(32'h0000_0100);
    push_line(32'h0000_0340);
    fe_q.push_back(memword(32'h0000_0340));
    m0 = mem_acks;
    fe_bus.fe_addr = 32'h0000_0100;
    fe_bus.fe_req  = 1'b1;
    wait_mem(m0 + 2);
    fe_bus.fe_addr = 32'h0000_0340;
    wait_ack(c1);
    chk("redirect_words", 32'(mem_acks - m0), 32'(2 * WPL));
    chk("redirect_ack_delay", 32'(c1 - last_ack_cyc), 32'd2);
    fe_bus.fe_req = 1'b0;
    idle(2);
    fetch_hit(32'h0000_010C, 1);
    idle(2);
    fetch_hit(32'h0000_0344, 1);
    idle(2);

    // Reset in the middle of a refill of a cold line (0x180, index 8).
    mem_q.push_back(32'h0000_0180);
    m0 = mem_acks;
    fe_bus.fe_addr = 32'h0000_0180;
    fe_bus.fe_req  = 1'b1;
    wait_mem(m0 + 1);
    step();
    reset_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    chk("midrst_fe_ack", 32'(fe_bus.fe_ack), 32'd0);
    chk("midrst_mem_addr", mem_bus.mem_addr, 32'd0);
    fe_bus.fe_req = 1'b0;
    idle(2);
    chk("midrst_acks", 32'(mem_acks - m0), 32'd1);
    reset_n = 1'b1;
    idle(2);
    fetch_miss(32'h0000_0100);
    idle(2);
    fetch_miss(32'h0000_0344);
    idle(2);

`ifdef ICACHE_FENCEI_EN
    // Flush pulse invalidates a filled line.
    fetch_hit(32'h0000_0100, 1);
    idle(2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(1);
    fetch_miss(32'h0000_0100);
    idle(2);

    // Flush during refill: line is installed invalid, so the re-lookup refills.
    flush = 1'b1;
    step();
    flush = 1'b0;
    push_line(32'h0000_0100);
    push_line(32'h0000_0100);
    fe_q.push_back(memword(32'h0000_0108));
    m0 = mem_acks;
    fe_bus.fe_addr = 32'h0000_0108;
    fe_bus.fe_req  = 1'b1;
    wait_mem(m0 + 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_ack(c1);
    chk("flush_refill_words", 32'(mem_acks - m0), 32'(2 * WPL));
    chk("flush_refill_delay", 32'(c1 - last_ack_cyc), 32'd2);
    fe_bus.fe_req = 1'b0;
    idle(2);
    fetch_hit(32'h0000_0104, 1);
    idle(2);

    // Flush together with a request on a valid line forces a miss.
    fe_q.push_back(memword(32'h0000_010C));
    push_line(32'h0000_010C);
    m0 = mem_acks;
    flush = 1'b1;
    fe_bus.fe_addr = 32'h0000_010C;
    fe_bus.fe_req  = 1'b1;
    step();
    flush = 1'b0;
    wait_ack(c1);
    chk("flush_req_words", 32'(mem_acks - m0), 32'(WPL));
    fe_bus.fe_req = 1'b0;
    idle(2);
`endif

    idle(4);
    chk("fe_queue_empty", 32'(fe_q.size()), 32'd0);
    chk("mem_queue_empty", 32'(mem_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache; the responder on the fetch-stage request/ack interface (fe_req/fe_addr/fe_ack/fe_data).
- On a miss it refills the whole line from the unified memory through a word-wide req/ack initiator port.
- Sits between stage_fetch and memory in top, replacing the direct fetch connection to memory.

Parameters:
- LINES, 16, number of cache lines; power of two, ≥2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, ≥2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- fe_req  in  1  fetch request; held high with fe_addr stable until fe_ack
- fe_addr  in  32  byte address; bits [1:0] ignored
- fe_ack  out  1  one-cycle pulse; fe_data valid in that cycle
- fe_data  out  32  instruction word
- mem_req  out  1  refill word request; held with mem_addr until mem_ack
- mem_addr  out  32  word-aligned refill address
- mem_ack  in  1  one-cycle pulse; mem_data valid
- mem_data  in  32  refill word

Behaviour:
- Reset is asynchronous, active-low, on reset_n; the block uses the single clock clk.
- Reset values: all valid bits 0, state IDLE, fe_ack=0, fe_data=0, mem_req=0, mem_addr=0. Tag/data storage is not reset.
- Address split:
  - offset = fe_addr[OB+1:2], OB = log2(WORDS_PER_LINE)
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- States:
  - IDLE: fe_req sampled. Hit (valid[index] and tag match) -> HIT_ACK, with fe_ack=1 and fe_data=word registered for the next cycle. Miss -> REFILL; capture line base (fe_addr with offset and byte bits zeroed), mem_addr=base, mem_req=1 next cycle, word counter=0.
  - HIT_ACK: fe_ack high exactly one cycle, then -> IDLE. fe_addr in this cycle is the old address and is not sampled. Hit throughput is one fetch per 2 cycles.
  - REFILL: on mem_ack, write mem_data into data[index][counter] and increment the counter.
    - If counter < WORDS_PER_LINE-1: mem_addr += 4 and mem_req stays high. The memory side treats req high after an ack as a new request.
    - Last word: write tag, set valid[index], mem_req=0, -> IDLE. The re-lookup then hits and acks.
- Miss latency from request sample to fe_ack = sum of WORDS_PER_LINE memory transactions + 2 cycles.
- Fetch redirect mid-refill (fe_req dropped or fe_addr changed): the refill always completes and the line is installed. No ack is issued for the abandoned address. IDLE then services the current request.
- fe_ack is never asserted while fe_req=0 at the sampling cycle.
- Miss on an occupied index evicts the old line. There is no writeback because the cache is read-only.
- Reset mid-refill: everything returns to reset values immediately; mem_req drops asynchronously. A partial line is never marked valid.
- No internal sampling occurs except in IDLE.

Optional Feature:
- Macro: ICACHE_FENCEI_EN.
- With the macro: adds input port flush (1 bit, fence.i from decode).
  - flush high in any cycle clears all valid bits at the next edge.
  - Flush during REFILL: the refill completes but its valid bit is not set. A flush-pending flag suppresses it, and the flag clears on return to IDLE.
  - Flush in IDLE with a simultaneous fe_req: treated as a miss. flush has priority over the lookup.
  - Flush during HIT_ACK: the ack still completes.
- Without the macro: no flush port; valid bits are cleared only by reset.

Decomposition:
- Package icache_pkg holds:
  - the state enum (IDLE, HIT_ACK, REFILL)
  - helper functions computing OB, index width and tag width from the parameters
  - the 32-bit address/word width constants
- One sub-module, icache_array: parameterised tag+valid+data storage with asynchronous-read lookup, a single word write port, a tag-install port and valid-clear. The FSM/counter stays in icache.

Test Plan:
- Cold miss, LINES=16, WORDS_PER_LINE=4: fe_req at 0x100 -> mem_req addresses 0x100, 0x104, 0x108, 0x10C in order; then fe_ack with fe_data = memory[0x100], exactly 2 cycles after the 4th mem_ack.
- Hit after fill: fe_req 0x108 -> fe_ack in the next cycle with memory[0x108], mem_req stays 0. Back-to-back requests are acked every 2 cycles.
- Conflict eviction: fill 0x100, request 0x200 (same index 0, different tag) -> refill 0x200–0x20C. Re-request 0x100 -> miss again.
- Redirect mid-refill: fe_req 0x100 changed to 0x300 after the 2nd mem_ack -> no ack for 0x100; line 0x100 is valid. Then a refill of 0x300 follows, and fe_ack returns memory[0x300].
- Reset mid-refill: assert reset_n=0 after the 1st mem_ack -> mem_req=0 and fe_ack=0 immediately. After release, 0x100 misses again.
- ICACHE_FENCEI_EN: fill 0x100, pulse flush -> next fe_req 0x100 misses. Flush during refill -> the line is not valid and the re-lookup refills it.
